mem_line_responder: RTL and testbench

Memory-side responder for the cache controller↔memory interface in cache_def. It accepts mem_req_type line requests (128-bit line read or write-back) from the cache controller and serves them from an internal line store. After a fixed, parameterised latency it returns a mem_data_type response with a one-cycle ready pulse. It is the synthesizable main-memory model behind the cache in simulation and FPGA builds.

---
 rtl/mem_line_responder_pkg.sv | 24 ++
 rtl/mem_line_ram.sv | 22 ++
 rtl/mem_line_responder.sv | 113 +++++++++++
 tb/tb_mem_line_responder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared types for the cache controller <-> memory interface: line geometry,
// request/response structs and the responder state encoding.
package mem_line_responder_pkg;

  localparam int LINE_BYTES    = 16;
  localparam int LINE_OFFSET_W = 4;

  // Line request from the cache controller (rw=1 is a write-back).
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  // Line response to the cache controller; ready pulses for one cycle.
  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_RESP} mem_state_type;

endpackage

// File: rtl/mem_line_ram.sv
// Single-port 128-bit line store: synchronous write, combinational read at
// the same index. Contents are never reset.
module mem_line_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [127:0]             wdata,
  output logic [127:0]             rdata
);

  logic [127:0] mem [DEPTH];

  // Write the addressed line when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: accepts one line request at a time, and after a
// fixed LATENCY returns the line (or echoes the written line) with a
// one-cycle ready pulse.
//
// Handshake: a request is taken when mem_req.valid is high at a rising edge
// while the responder is idle (busy=0). mem_req is ignored from then until
// the cycle after the ready pulse; mem_data.ready is high for exactly one
// cycle, and mem_data.data is valid in that cycle and holds afterwards.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_type    state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [127:0]     data_q;
  logic             rw_q;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] ram_idx;
  logic [127:0]     ram_wdata;
  logic [127:0]     ram_rdata;
  logic             ram_we;
  logic             enter_resp;
  logic             resp_is_write;
  logic             unused_addr_bits;

  // Offset and upper address bits do not select a line; lines alias modulo DEPTH.
  assign req_idx          = mem_req.addr[LINE_OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^{mem_req.addr[31:LINE_OFFSET_W+IDX_W],
                              mem_req.addr[LINE_OFFSET_W-1:0]};

  // Select the request feeding the store: the live one when a LATENCY=1
  // request goes straight to RESP, otherwise the latched one.
  always_comb begin
    ram_idx       = idx_q;
    ram_wdata     = data_q;
    resp_is_write = rw_q;
    enter_resp    = 1'b0;
    case (state)
      MEM_IDLE: begin
        ram_idx       = req_idx;
        ram_wdata     = mem_req.data;
        resp_is_write = mem_req.rw;
        enter_resp    = mem_req.valid && (LATENCY == 1);
      end
      MEM_BUSY: enter_resp = (cnt == CNT_W'(1));
      default:  enter_resp = 1'b0;
    endcase
  end

  // The store is written only on the edge entering RESP, so a reset before
  // that point discards the pending write.
  assign ram_we = enter_resp && resp_is_write && !rst;

  mem_line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Request FSM, latency counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      rw_q     <= 1'b0;
      mem_data <= '0;
    end else begin
      mem_data.ready <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (mem_req.valid) begin
            idx_q  <= req_idx;
            data_q <= mem_req.data;
            rw_q   <= mem_req.rw;
            cnt    <= CNT_LOAD;
            state  <= (LATENCY == 1) ? MEM_RESP : MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MEM_RESP;
        end
        default: state <= MEM_IDLE;
      endcase
      if (enter_resp) begin
        mem_data.ready <= 1'b1;
        mem_data.data  <= resp_is_write ? ram_wdata : ram_rdata;
      end
    end
  end

  assign busy = (state != MEM_IDLE);

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a LATENCY=4/DEPTH=1024 instance and
// a LATENCY=1/DEPTH=16 instance. Expected response data is queued when a
// request is driven and compared when ready pulses.
module tb_mem_line_responder;
  import mem_line_responder_pkg::*;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  mem_req_type  req, req1;
  mem_data_type md, md1;
  logic         busy, busy1;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp1_q[$];

  always #5 clk = ~clk;

  mem_line_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_data(md), .busy(busy)
  );

  mem_line_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_data(md1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the LATENCY=4 instance.
  always @(negedge clk) begin
    if (!rst && md.ready) begin
      chk("resp_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) chk("resp_data", md.data, exp_q.pop_front());
    end
  end

  // Scoreboard for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (!rst && md1.ready) begin
      chk("l1_resp_expected", 128'(exp1_q.size() != 0), 128'd1);
      if (exp1_q.size() != 0) chk("l1_resp_data", md1.data, exp1_q.pop_front());
    end
  end

  // Called at a negedge with the responder idle; returns at a negedge one
  // cycle after the ready pulse, so the next call is back-to-back.
  task automatic run_req(input logic [31:0] addr, input logic [127:0] data, input logic rw,
                         input logic [127:0] exp, input logic hold, input string tag);
    req.addr  = addr;
    req.data  = data;
    req.rw    = rw;
    req.valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (!hold && k == 1) req.valid = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_ready"}, md.ready, (k == LAT));
    end
    @(negedge clk);
    req.valid = 1'b0;
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_ready"}, md.ready, 1'b0);
    chk({tag, "_data_hold"}, md.data, exp);
  endtask

  task automatic run_req1(input logic [31:0] addr, input logic [127:0] data, input logic rw,
                          input logic [127:0] exp, input string tag);
    req1.addr  = addr;
    req1.data  = data;
    req1.rw    = rw;
    req1.valid = 1'b1;
    exp1_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    req1.valid = 1'b0;
    chk({tag, "_busy"}, busy1, 1'b1);
    chk({tag, "_ready"}, md1.ready, 1'b1);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy1, 1'b0);
    chk({tag, "_idle_ready"}, md1.ready, 1'b0);
    chk({tag, "_data_hold"}, md1.data, exp);
  endtask

  initial begin
    logic [127:0] d_wr, d_a5, d9, d5, d3, d_l1;
    d_wr = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    d_a5 = {16{8'hA5}};
    d9   = {$urandom(), $urandom(), $urandom(), $urandom()};
    d5   = {$urandom(), $urandom(), $urandom(), $urandom()};
    d3   = {$urandom(), $urandom(), $urandom(), $urandom()};
    d_l1 = {$urandom(), $urandom(), $urandom(), $urandom()};

    req  = '0;
    req1 = '0;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready", md.ready, 1'b0);
    chk("reset_data", md.data, 128'd0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Write then read the same line, offset bits ignored.
    run_req(32'h0000_0040, d_wr, 1'b1, d_wr, 1'b0, "wr40");
    run_req(32'h0000_004C, 128'd0, 1'b0, d_wr, 1'b0, "rd4c");

    // Aliasing modulo 1024 lines.
    run_req(32'h0000_0010, d_a5, 1'b1, d_a5, 1'b0, "wr10");
    run_req(32'h0000_4010, 128'd0, 1'b0, d_a5, 1'b0, "rd4010");

    // Write-back to line 5 holding valid through RESP, then read line 9
    // on the first idle cycle.
    run_req(32'h0000_0090, d9, 1'b1, d9, 1'b0, "wr9");
    run_req(32'h0000_0050, d5, 1'b1, d5, 1'b1, "wb5");
    run_req(32'h0000_0090, 128'd0, 1'b0, d9, 1'b0, "rd9");
    run_req(32'h0000_0050, 128'd0, 1'b0, d5, 1'b0, "rd5");

    // Reset during a pending write of line 3.
    run_req(32'h0000_0030, d3, 1'b1, d3, 1'b0, "wr3");
    req.addr  = 32'h0000_0030;
    req.data  = {128{1'b1}};
    req.rw    = 1'b1;
    req.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req.valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", md.ready, 1'b0);
    chk("abort_data", md.data, 128'd0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_req(32'h0000_0030, 128'd0, 1'b0, d3, 1'b0, "rd3");

    // LATENCY=1 instance: write, read, alias modulo 16 lines.
    run_req1(32'h0000_0020, d_l1, 1'b1, d_l1, "l1_wr");
    run_req1(32'h0000_0020, 128'd0, 1'b0, d_l1, "l1_rd");
    run_req1(32'h0000_0120, 128'd0, 1'b0, d_l1, "l1_alias");

    repeat (3) @(negedge clk);
    chk("pending_resp", 128'(exp_q.size()), 128'd0);
    chk("l1_pending_resp", 128'(exp1_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
